spi_mnrch: RTL and testbench

SPI monarch (initiator) for the inertial-sensor link. It runs a 16-bit full-duplex transaction on a single request pulse, generating SS_n, SCLK and MOSI and capturing MISO. It sits between the inertial interface state machine and the sensor pins. It is the initiator end of the same SPI link the sensor serves:
- SCLK idles high.
- The serf drives MISO on SCLK fall and samples MOSI on SCLK rise.
- The serf ignores the first SCLK fall after SS_n goes low (front porch).

---
 rtl/spi_pkg.sv | 38 +++
 rtl/spi_sclk_gen.sv | 42 ++++
 rtl/spi_mnrch.sv | 140 ++++++++++++++
 tb/tb_spi_mnrch.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg -- shared types and constants for the SPI monarch.
//   state_t   : transaction FSM states (IDLE, PORCH, SHIFT, BACK)
//   BITS      : transaction word width
//   DIV_W_DFLT: default SCLK divider width
//   SMPL_CODE / SHFT_CODE / LOAD_CODE : divider decode values at the default
//   width; the *_code() helpers give the same values for any divider width.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PORCH = 2'd1,
        SHIFT = 2'd2,
        BACK  = 2'd3
    } state_t;

    localparam int BITS       = 16;
    localparam int DIV_W_DFLT = 4;

    // Divider value one clock before SCLK rises (MISO sample point).
    function automatic int smpl_code(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    // Divider value one clock before SCLK falls (shift point).
    function automatic int shft_code(input int dw);
        return (1 << dw) - 1;
    endfunction

    // Load value on accept: gives a 5-clock SS_n-to-first-fall setup.
    function automatic int load_code(input int dw);
        return (1 << dw) - 5;
    endfunction

    localparam int SMPL_CODE = smpl_code(DIV_W_DFLT);
    localparam int SHFT_CODE = shft_code(DIV_W_DFLT);
    localparam int LOAD_CODE = load_code(DIV_W_DFLT);

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen -- SCLK divider for the SPI monarch.
//   clk, rst_n : system clock, asynchronous active-low reset
//   load       : preload divider with the setup count (transaction accept)
//   hold       : freeze divider (idle, and at the end of the back porch)
//   smpl       : decoded one clock before SCLK rises
//   shft       : decoded one clock before SCLK falls
//   SCLK       : divider MSB; idles high since the divider resets to all-ones
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = DIV_W_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic hold,
    output logic smpl,
    output logic shft,
    output logic SCLK
);

    localparam logic [DIV_W-1:0] SMPL_VAL = DIV_W'(smpl_code(DIV_W));
    localparam logic [DIV_W-1:0] SHFT_VAL = DIV_W'(shft_code(DIV_W));
    localparam logic [DIV_W-1:0] LOAD_VAL = DIV_W'(load_code(DIV_W));

    logic [DIV_W-1:0] div_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= '1;
        end else if (load) begin
            div_reg <= LOAD_VAL;
        end else if (!hold) begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

    assign SCLK = div_reg[DIV_W-1];
    assign smpl = (div_reg == SMPL_VAL);
    assign shft = (div_reg == SHFT_VAL);

endmodule

// File: rtl/spi_mnrch.sv
// spi_mnrch -- SPI monarch: 16-bit full-duplex transaction per wrt pulse.
//   clk, rst_n : system clock, asynchronous active-low reset
//   wrt        : start pulse, wt_data sampled on the accepting clock
//   done       : transaction complete, cleared on the next accept
//   rd_data    : received word (valid while done)
//   SS_n, SCLK, MOSI : serf select, serial clock (idles high), serial out
//   MISO       : serial in, sampled on SCLK rise
// Build option SPI_MNRCH_PEND_EN: one-deep pending word; a wrt while busy is
// held and launched automatically one clock after the current transaction.
module spi_mnrch
    import spi_pkg::*;
#(
    parameter int DIV_W = DIV_W_DFLT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wrt,
    input  logic [BITS-1:0] wt_data,
    output logic            done,
    output logic [BITS-1:0] rd_data,
    output logic            SS_n,
    output logic            SCLK,
    output logic            MOSI,
    input  logic            MISO
);

    state_t            state_reg, state_next;
    logic [BITS-1:0]   shft_reg;
    logic              miso_smpl_reg;
    logic [4:0]        bit_cnt_reg;
    logic              done_reg;
    logic              ss_n_reg;
    logic              smpl, shft, load, hold;
    logic              launch;
    logic [BITS-1:0]   launch_data;

    spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .hold  (hold),
        .smpl  (smpl),
        .shft  (shft),
        .SCLK  (SCLK)
    );

`ifdef SPI_MNRCH_PEND_EN
    logic [BITS-1:0] pend_data_reg;
    logic            pend_vld_reg;

    // A held word takes priority over a fresh wrt arriving in the same idle clock.
    assign launch      = (state_reg == IDLE) && (pend_vld_reg || wrt);
    assign launch_data = pend_vld_reg ? pend_data_reg : wt_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data_reg <= '0;
            pend_vld_reg  <= 1'b0;
        end else if (state_reg == IDLE) begin
            pend_vld_reg <= 1'b0;
        end else if (wrt && !pend_vld_reg) begin
            pend_data_reg <= wt_data;
            pend_vld_reg  <= 1'b1;
        end
    end
`else
    assign launch      = (state_reg == IDLE) && wrt;
    assign launch_data = wt_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        hold       = 1'b0;
        case (state_reg)
            IDLE: begin
                hold = 1'b1;
                if (launch) begin
                    load       = 1'b1;
                    state_next = PORCH;
                end
            end
            PORCH: begin
                if (shft) state_next = SHIFT;
            end
            SHIFT: begin
                // Leave on the last sample: the final shift happens in BACK.
                if (smpl && bit_cnt_reg == 5'(BITS - 1)) state_next = BACK;
            end
            BACK: begin
                if (shft) begin
                    hold       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shft_reg      <= '0;
            miso_smpl_reg <= 1'b0;
            bit_cnt_reg   <= '0;
            done_reg      <= 1'b0;
            ss_n_reg      <= 1'b1;
        end else if (launch) begin
            shft_reg    <= launch_data;
            bit_cnt_reg <= '0;
            done_reg    <= 1'b0;
            ss_n_reg    <= 1'b0;
        end else begin
            if (state_reg == SHIFT && smpl && !ss_n_reg) begin
                miso_smpl_reg <= MISO;
                bit_cnt_reg   <= bit_cnt_reg + 5'd1;
            end
            if ((state_reg == SHIFT || state_reg == BACK) && shft) begin
                shft_reg <= {shft_reg[BITS-2:0], miso_smpl_reg};
            end
            if (state_reg == BACK && shft) begin
                ss_n_reg <= 1'b1;
                done_reg <= 1'b1;
            end
        end
    end

    assign done    = done_reg;
    assign SS_n    = ss_n_reg;
    assign rd_data = shft_reg;
    assign MOSI    = shft_reg[BITS-1];

endmodule

// File: tb/tb_spi_mnrch.sv
// tb_spi_mnrch -- directed bench for spi_mnrch with a loopback / word-returning serf.
module tb_spi_mnrch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wrt = 1'b0;
    logic [15:0] wt_data = 16'h0000;
    logic        done;
    logic [15:0] rd_data;
    logic        SS_n, SCLK, MOSI, MISO;

    spi_mnrch dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .wt_data (wt_data),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    always #10 clk = ~clk;

    int vec = 0;
    int bad = 0;
    int cyc = 0;
    int e0  = 0;

    logic        loop_mode = 1'b1;
    logic [15:0] serf_word = 16'h0000;
    logic [15:0] serf_sr   = 16'h0000;
    bit          first_fall = 1'b0;
    int          rise_cnt = 0;
    int          win_cnt  = 0;
    int          ss_hi_cyc = 0;
    int          ss_gap = 0;
    logic [15:0] mosi_cap = 16'h0000;

    always @(posedge clk) cyc++;

    assign MISO = loop_mode ? MOSI : serf_sr[15];

    always @(negedge SS_n) begin
        serf_sr    = serf_word;
        first_fall = 1'b1;
        win_cnt++;
        ss_gap = cyc - ss_hi_cyc;
    end

    always @(posedge SS_n) ss_hi_cyc = cyc;

    always @(negedge SCLK) begin
        if (!SS_n) begin
            if (first_fall) first_fall = 1'b0;
            else            serf_sr = {serf_sr[14:0], 1'b0};
        end
    end

    always @(posedge SCLK) begin
        if (!SS_n) begin
            rise_cnt++;
            mosi_cap = {mosi_cap[14:0], MOSI};
        end
    end

    task automatic send(input logic [15:0] w);
        @(negedge clk);
        wrt = 1'b1;
        wt_data = w;
        @(posedge clk);
        #1;
        wrt = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(output int lat);
        int n;
        n = 0;
        while (!done && n < 700) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat = cyc - e0;
        $display("txn: done after %0d clocks, rd_data=%h", lat, rd_data);
    endtask

    task automatic test_reset();
        #5 rst_n = 1'b0;
        #10;
        vec++; if (SS_n !== 1'b1) begin bad++; $display("FAIL reset_ss_n: got %b want 1", SS_n); end
        vec++; if (SCLK !== 1'b1) begin bad++; $display("FAIL reset_sclk: got %b want 1", SCLK); end
        vec++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        vec++; if (rd_data !== 16'h0000) begin bad++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
        vec++; if (MOSI !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b want 0", MOSI); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_loopback();
        int lat;
        loop_mode = 1'b1;
        rise_cnt = 0;
        send(16'hA55A);
        vec++; if (SS_n !== 1'b0) begin bad++; $display("FAIL loop_ss_low: got %b want 0", SS_n); end
        wait_done(lat);
        vec++; if (lat !== 261) begin bad++; $display("FAIL loop_latency: got %0d want 261", lat); end
        vec++; if (rd_data !== 16'hA55A) begin bad++; $display("FAIL loop_rd_data: got %h want a55a", rd_data); end
        vec++; if (rise_cnt !== 16) begin bad++; $display("FAIL loop_sclk_rises: got %0d want 16", rise_cnt); end
        vec++; if (SS_n !== 1'b1 || SCLK !== 1'b1) begin bad++; $display("FAIL loop_idle_pins: got ss_n=%b sclk=%b want 1 1", SS_n, SCLK); end
    endtask

    task automatic test_serf();
        int lat;
        loop_mode = 1'b0;
        serf_word = 16'h00A5;
        mosi_cap = 16'h0000;
        send(16'h8F00);
        wait_done(lat);
        vec++; if (mosi_cap !== 16'h8F00) begin bad++; $display("FAIL serf_mosi: got %h want 8f00", mosi_cap); end
        vec++; if (rd_data !== 16'h00A5) begin bad++; $display("FAIL serf_rd_data: got %h want 00a5", rd_data); end
        vec++; if (lat !== 261) begin bad++; $display("FAIL serf_latency: got %0d want 261", lat); end
        loop_mode = 1'b1;
    endtask

    task automatic test_busy_wrt();
        int lat;
        loop_mode = 1'b1;
        win_cnt = 0;
        send(16'h3C96);
        repeat (99) @(posedge clk);
        @(negedge clk);
        wrt = 1'b1;
        wt_data = 16'h5A0F;
        @(posedge clk);
        #1;
        wrt = 1'b0;
        wait_done(lat);
        vec++; if (lat !== 261) begin bad++; $display("FAIL busy_latency1: got %0d want 261", lat); end
        vec++; if (rd_data !== 16'h3C96) begin bad++; $display("FAIL busy_rd_data1: got %h want 3c96", rd_data); end
`ifdef SPI_MNRCH_PEND_EN
        @(posedge clk);
        #1;
        vec++; if (done !== 1'b0) begin bad++; $display("FAIL pend_done_pulse: got %b want 0", done); end
        vec++; if (SS_n !== 1'b0) begin bad++; $display("FAIL pend_relaunch: got %b want 0", SS_n); end
        vec++; if (ss_gap !== 1) begin bad++; $display("FAIL pend_ss_gap: got %0d want 1", ss_gap); end
        mosi_cap = 16'h0000;
        wait_done(lat);
        vec++; if (lat !== 523) begin bad++; $display("FAIL pend_latency2: got %0d want 523", lat); end
        vec++; if (mosi_cap !== 16'h5A0F) begin bad++; $display("FAIL pend_mosi: got %h want 5a0f", mosi_cap); end
        vec++; if (rd_data !== 16'h5A0F) begin bad++; $display("FAIL pend_rd_data: got %h want 5a0f", rd_data); end
        vec++; if (win_cnt !== 2) begin bad++; $display("FAIL pend_windows: got %0d want 2", win_cnt); end
`else
        repeat (20) @(posedge clk);
        #1;
        vec++; if (win_cnt !== 1) begin bad++; $display("FAIL busy_windows: got %0d want 1", win_cnt); end
        vec++; if (SS_n !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL busy_idle: got ss_n=%b done=%b want 1 1", SS_n, done); end
`endif
    endtask

    task automatic test_reset_mid();
        int lat;
        loop_mode = 1'b1;
        send(16'h1234);
        repeat (130) @(posedge clk);
        #1;
        vec++; if (SS_n !== 1'b0) begin bad++; $display("FAIL mid_active: got %b want 0", SS_n); end
        rst_n = 1'b0;
        #1;
        vec++; if (SS_n !== 1'b1) begin bad++; $display("FAIL mid_ss_n: got %b want 1", SS_n); end
        vec++; if (SCLK !== 1'b1) begin bad++; $display("FAIL mid_sclk: got %b want 1", SCLK); end
        vec++; if (done !== 1'b0) begin bad++; $display("FAIL mid_done: got %b want 0", done); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        send(16'hC3A5);
        wait_done(lat);
        vec++; if (lat !== 261) begin bad++; $display("FAIL mid_latency: got %0d want 261", lat); end
        vec++; if (rd_data !== 16'hC3A5) begin bad++; $display("FAIL mid_rd_data: got %h want c3a5", rd_data); end
    endtask

    task automatic test_wrt_on_done();
        int lat;
        loop_mode = 1'b1;
        send(16'h6666);
        repeat (260) @(posedge clk);
        @(negedge clk);
        wrt = 1'b1;
        wt_data = 16'h9999;
        @(posedge clk);
        #1;
        wrt = 1'b0;
        vec++; if (done !== 1'b1 || SS_n !== 1'b1) begin bad++; $display("FAIL ondone_end: got done=%b ss_n=%b want 1 1", done, SS_n); end
        @(posedge clk);
        #1;
`ifdef SPI_MNRCH_PEND_EN
        vec++; if (SS_n !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL ondone_pended: got ss_n=%b done=%b want 0 0", SS_n, done); end
        wait_done(lat);
        vec++; if (rd_data !== 16'h9999) begin bad++; $display("FAIL ondone_pend_rd: got %h want 9999", rd_data); end
`else
        vec++; if (SS_n !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL ondone_ignored: got ss_n=%b done=%b want 1 1", SS_n, done); end
        vec++; if (rd_data !== 16'h6666) begin bad++; $display("FAIL ondone_rd: got %h want 6666", rd_data); end
`endif
    endtask

    task automatic test_back_to_back();
        int lat;
        loop_mode = 1'b1;
        send(16'h0F0F);
        wait_done(lat);
        vec++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done1: got %b want 1", done); end
        vec++; if (rd_data !== 16'h0F0F) begin bad++; $display("FAIL b2b_rd1: got %h want 0f0f", rd_data); end
        send(16'hF00F);
        vec++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_clear: got %b want 0", done); end
        vec++; if (SS_n !== 1'b0) begin bad++; $display("FAIL b2b_accept: got %b want 0", SS_n); end
        vec++; if (ss_gap !== 1) begin bad++; $display("FAIL b2b_ss_gap: got %0d want 1", ss_gap); end
        wait_done(lat);
        vec++; if (lat !== 261) begin bad++; $display("FAIL b2b_latency2: got %0d want 261", lat); end
        vec++; if (rd_data !== 16'hF00F) begin bad++; $display("FAIL b2b_rd2: got %h want f00f", rd_data); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_serf();
        test_busy_wrt();
        test_reset_mid();
        test_wrt_on_done();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit, %0d vectors applied", vec);
        $fatal(1, "timeout");
    end

endmodule
